// File: rtl/ov7670_transmitter.sv
// Emulates an OV7670 sensor: fetches RGB565 pixels from a source and streams them as bytes with PCLK/VSYNC/HREF.
// Fetch leads the high-byte slot by one slot; no backpressure, the source must answer in the cycle after o_rd_en.
module ov7670_transmitter #(
  parameter int H_WIDTH  = 320,
  parameter int V_WIDTH  = 240,
  parameter int H_BLANK  = 144,
  parameter int VS_LINES = 3,
  parameter int V_BACK   = 17,
  parameter int V_FRONT  = 10
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_enable,
  input  logic [15:0]                i_pixel_data,
  output logic                       o_rd_en,
  output logic [$clog2(H_WIDTH)-1:0] o_h_addr,
  output logic [$clog2(V_WIDTH)-1:0] o_v_addr,
  output logic                       o_PCLK,
  output logic                       o_VS,
  output logic                       o_HS,
  output logic [7:0]                 o_DATA,
  output logic                       o_frame_done,
  output logic                       o_busy
);

  localparam int SLOTS     = 2*H_WIDTH + H_BLANK;
  localparam int ACT_SLOTS = 2*H_WIDTH;
  localparam int SW        = $clog2(SLOTS);
  localparam int MAXA      = (VS_LINES > V_BACK) ? VS_LINES : V_BACK;
  localparam int MAXB      = (V_WIDTH > V_FRONT) ? V_WIDTH : V_FRONT;
  localparam int MAXL      = (MAXA > MAXB) ? MAXA : MAXB;
  localparam int LW        = $clog2(MAXL + 1);
  localparam int HAW       = $clog2(H_WIDTH);
  localparam int VAW       = $clog2(V_WIDTH);

  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_BACK, S_ACTIVE, S_FRONT} state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    slot_q, slot_d;
  logic [LW-1:0]    line_q, line_d;
  logic             pclk_q, pclk_d;
  logic             vs_q, vs_d;
  logic             hs_q, hs_d;
  logic [7:0]       data_q, data_d;
  logic [15:0]      pix_q, pix_d;
  logic             rd_en_q, rd_en_d;
  logic [HAW-1:0]   h_addr_q, h_addr_d;
  logic [VAW-1:0]   v_addr_q, v_addr_d;

  function automatic int region_lines(input state_t s);
    case (s)
      S_VSYNC:  return VS_LINES;
      S_BACK:   return V_BACK;
      S_ACTIVE: return V_WIDTH;
      S_FRONT:  return V_FRONT;
      default:  return 1;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    line_d   = line_q;
    pclk_d   = ~pclk_q;
    vs_d     = vs_q;
    hs_d     = hs_q;
    data_d   = data_q;
    pix_d    = pix_q;
    rd_en_d  = 1'b0;
    h_addr_d = h_addr_q;
    v_addr_d = v_addr_q;

    // Everything advances at the end of cycle B so outputs change only at the start of cycle A.
    if (pclk_q) begin
      if (state_q == S_IDLE) begin
        if (i_enable) begin
          state_d = S_VSYNC;
          slot_d  = '0;
          line_d  = '0;
        end
      end else if (int'(slot_q) == SLOTS-1) begin
        slot_d = '0;
        if (int'(line_q) == region_lines(state_q) - 1) begin
          line_d = '0;
          case (state_q)
            S_VSYNC:  state_d = S_BACK;
            S_BACK:   state_d = S_ACTIVE;
            S_ACTIVE: state_d = S_FRONT;
            default:  state_d = i_enable ? S_VSYNC : S_IDLE;
          endcase
        end else begin
          line_d = line_q + 1'b1;
        end
      end else begin
        slot_d = slot_q + 1'b1;
      end

      vs_d   = (state_d == S_VSYNC);
      hs_d   = (state_d == S_ACTIVE) && (int'(slot_d) < ACT_SLOTS);
      data_d = 8'h00;
      if (hs_d) begin
        if (!slot_d[0]) begin
          data_d = i_pixel_data[15:8];
          pix_d  = i_pixel_data;
        end else begin
          data_d = pix_q[7:0];
        end
      end

      // Fetch in the slot before each high byte; pixel 0 of a line is fetched in the last slot of the previous line.
      if ((state_d == S_ACTIVE) && slot_d[0] && (int'(slot_d) < ACT_SLOTS-1)) begin
        rd_en_d  = 1'b1;
        h_addr_d = HAW'((int'(slot_d) + 1) / 2);
        v_addr_d = VAW'(int'(line_d));
      end else if ((int'(slot_d) == SLOTS-1) &&
                   (((state_d == S_BACK) && (int'(line_d) == V_BACK-1)) ||
                    ((state_d == S_ACTIVE) && (int'(line_d) < V_WIDTH-1)))) begin
        rd_en_d  = 1'b1;
        h_addr_d = '0;
        v_addr_d = (state_d == S_BACK) ? '0 : VAW'(int'(line_d) + 1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= S_IDLE;
      slot_q   <= '0;
      line_q   <= '0;
      pclk_q   <= 1'b0;
      vs_q     <= 1'b0;
      hs_q     <= 1'b0;
      data_q   <= 8'h00;
      pix_q    <= 16'h0000;
      rd_en_q  <= 1'b0;
      h_addr_q <= '0;
      v_addr_q <= '0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      line_q   <= line_d;
      pclk_q   <= pclk_d;
      vs_q     <= vs_d;
      hs_q     <= hs_d;
      data_q   <= data_d;
      pix_q    <= pix_d;
      rd_en_q  <= rd_en_d;
      h_addr_q <= h_addr_d;
      v_addr_q <= v_addr_d;
    end
  end

  assign o_PCLK       = pclk_q;
  assign o_VS         = vs_q;
  assign o_HS         = hs_q;
  assign o_DATA       = data_q;
  assign o_rd_en      = rd_en_q;
  assign o_h_addr     = h_addr_q;
  assign o_v_addr     = v_addr_q;
  assign o_busy       = (state_q != S_IDLE);
  assign o_frame_done = pclk_q && (state_q == S_FRONT) &&
                        (int'(slot_q) == SLOTS-1) && (int'(line_q) == V_FRONT-1);

endmodule
